// File: rtl/weapon_bank_ctrl.sv
// weapon_bank_ctrl: N independent ammo channels, each with a capacity, fire rate, timed reload FSM and sticky error.
// Optional feature: define AUTO_RELOAD_EN so that a channel fired dry re-enters RELOAD with its last loaded value.
module weapon_bank_ctrl #(
    parameter int         N           = 2,
    parameter int         W           = 9,
    parameter int         MAX_DEFAULT = 500,
    parameter int         RELOAD_CYC  = 4,
    parameter logic [3:0] ATTACK_MODE = 4'b0010
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     mode_sel,
    input  logic [N-1:0]   fire,
    input  logic [N-1:0]   load,
    input  logic [N*W-1:0] load_val,
    input  logic [N-1:0]   set_max,
    input  logic [N*W-1:0] max_val,
    input  logic [N*W-1:0] rate,
    input  logic [N-1:0]   err_clr,
    output logic [N*W-1:0] ammo,
    output logic [N-1:0]   shot,
    output logic [N-1:0]   busy,
    output logic [N-1:0]   error
);
    localparam int TW = RELOAD_CYC > 1 ? $clog2(RELOAD_CYC) : 1;

    typedef enum logic [1:0] {EMPTY, READY, FIRING, RELOAD} state_t;

    logic attack;

    // Exact compare: multi-hot or any other mode blocks firing.
    assign attack = mode_sel == ATTACK_MODE;

    for (genvar g = 0; g < N; g++) begin : ch
        state_t         st, st_n;
        logic [W-1:0]   am, am_n, cap, cap_n, capt, capt_n;
        logic [W-1:0]   lv, mv, rt, ld_c, dec;
        logic [TW-1:0]  tm, tm_n;
        logic           shot_r, shot_n, busy_r, err_r, err_n;
`ifdef AUTO_RELOAD_EN
        logic [W-1:0]   last, last_n;
`endif

        assign lv   = load_val[g*W +: W];
        assign mv   = max_val[g*W +: W];
        assign rt   = rate[g*W +: W];
        assign ld_c = lv > cap ? cap : lv;
        assign dec  = rt >= am ? '0 : am - rt;

        // Next-state logic: load beats fire; a capacity write clamps the result afterwards.
        always_comb begin
            st_n   = st;
            am_n   = am;
            cap_n  = set_max[g] ? mv : cap;
            capt_n = capt;
            tm_n   = tm;
            shot_n = 1'b0;
            err_n  = err_clr[g] ? 1'b0 : err_r;
`ifdef AUTO_RELOAD_EN
            last_n = last;
`endif
            if (load[g]) begin
                st_n   = RELOAD;
                capt_n = ld_c;
                tm_n   = TW'(RELOAD_CYC - 1);
                err_n  = lv > cap ? 1'b1 : err_n;
`ifdef AUTO_RELOAD_EN
                last_n = ld_c;
`endif
            end else begin
                err_n = fire[g] && (!attack || st == EMPTY || st == RELOAD) ? 1'b1 : err_n;
                if (st == RELOAD) begin
                    tm_n = tm != '0 ? tm - 1'b1 : tm;
                    am_n = tm == '0 ? capt : am;
                    st_n = tm != '0 ? RELOAD : capt != '0 ? READY : EMPTY;
                end else if (st != EMPTY) begin
                    if (fire[g] && attack) begin
                        am_n   = dec;
                        shot_n = am != '0;
                        st_n   = dec != '0 ? FIRING : EMPTY;
`ifdef AUTO_RELOAD_EN
                        if (dec == '0 && last != '0) begin
                            st_n   = RELOAD;
                            capt_n = last;
                            tm_n   = TW'(RELOAD_CYC - 1);
                        end
`endif
                    end else begin
                        st_n = READY;
                    end
                end
            end
            if (set_max[g]) begin
                capt_n = capt_n > mv ? mv : capt_n;
`ifdef AUTO_RELOAD_EN
                last_n = last_n > mv ? mv : last_n;
`endif
                if (am_n > mv) begin
                    am_n = mv;
                    st_n = mv == '0 && st_n != RELOAD ? EMPTY : st_n;
                end
            end
        end

        // Channel state and registered outputs.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                st     <= EMPTY;
                am     <= '0;
                cap    <= W'(MAX_DEFAULT);
                capt   <= '0;
                tm     <= '0;
                shot_r <= 1'b0;
                busy_r <= 1'b0;
                err_r  <= 1'b0;
`ifdef AUTO_RELOAD_EN
                last   <= '0;
`endif
            end else begin
                st     <= st_n;
                am     <= am_n;
                cap    <= cap_n;
                capt   <= capt_n;
                tm     <= tm_n;
                shot_r <= shot_n;
                busy_r <= st_n == RELOAD;
                err_r  <= err_n;
`ifdef AUTO_RELOAD_EN
                last   <= last_n;
`endif
            end
        end

        assign ammo[g*W +: W] = am;
        assign shot[g]        = shot_r;
        assign busy[g]        = busy_r;
        assign error[g]       = err_r;
    end
endmodule

// File: tb/tb_weapon_bank_ctrl.sv
// tb_weapon_bank_ctrl: directed checks of the two-channel weapon bank controller.
module tb_weapon_bank_ctrl;
    localparam int N = 2;
    localparam int W = 9;
`ifdef AUTO_RELOAD_EN
    localparam logic AR = 1'b1;
`else
    localparam logic AR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [3:0]     mode_sel = '0;
    logic [N-1:0]   fire = '0, load = '0, set_max = '0, err_clr = '0;
    logic [N*W-1:0] load_val = '0, max_val = '0, rate = '0;
    logic [N*W-1:0] ammo;
    logic [N-1:0]   shot, busy, error;
    int             n_run = 0;
    int             n_fail = 0;

    weapon_bank_ctrl #(
        .N(N), .W(W), .MAX_DEFAULT(500), .RELOAD_CYC(4), .ATTACK_MODE(4'b0010)
    ) dut (
        .clk(clk), .rst(rst), .mode_sel(mode_sel), .fire(fire), .load(load),
        .load_val(load_val), .set_max(set_max), .max_val(max_val), .rate(rate),
        .err_clr(err_clr), .ammo(ammo), .shot(shot), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] am(input int c);
        return ammo[c*W +: W];
    endfunction

    task automatic do_load(input int c, input logic [W-1:0] v);
        load_val[c*W +: W] = v;
        load[c] = 1'b1;
        tick();
        load[c] = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        // 1: reset values, held and after release
        repeat (2) tick();
        check("rst_ammo", 32'(ammo), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_error", 32'(error), 0);
        check("rst_shot", 32'(shot), 0);
        rst = 1'b1;
        tick();
        check("idle_ammo", 32'(ammo), 0);
        check("idle_flags", 32'({busy, error, shot}), 0);

        // 2: ch0 load 500, busy for exactly 4 cycles, then 10 shots at rate 5
        load_val[0 +: W] = 500;
        load[0] = 1'b1;
        tick();
        load[0] = 1'b0;
        check("ld_busy0", 32'(busy[0]), 1);
        check("ld_ammo_old", 32'(am(0)), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ld_busy", 32'(busy[0]), 1);
        end
        tick();
        check("ld_done_busy", 32'(busy[0]), 0);
        check("ld_done_ammo", 32'(am(0)), 500);
        check("ld_done_err", 32'(error[0]), 0);
        mode_sel = 4'b0010;
        rate[0 +: W] = 5;
        fire[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("burst_shot", 32'(shot[0]), 1);
            check("burst_ammo", 32'(am(0)), 32'(500 - 5 * k));
        end
        fire[0] = 1'b0;
        tick();
        check("cease_shot", 32'(shot[0]), 0);
        check("cease_ammo", 32'(am(0)), 450);

        // 3: ch1 7 rounds at rate 5 -> 2, 0 (saturated), then dry fire errors
        do_load(1, 7);
        check("ch1_ammo7", 32'(am(1)), 7);
        rate[W +: W] = 5;
        fire[1] = 1'b1;
        tick();
        check("ch1_two", 32'(am(1)), 2);
        check("ch1_shot_a", 32'(shot[1]), 1);
        tick();
        check("ch1_zero", 32'(am(1)), 0);
        check("ch1_shot_b", 32'(shot[1]), 1);
        check("ch1_err_none", 32'(error[1]), 0);
        check("ch1_dry_busy", 32'(busy[1]), 32'(AR));
        tick();
        check("ch1_dry_shot", 32'(shot[1]), 0);
        check("ch1_dry_err", 32'(error[1]), 1);
        check("ch0_untouched", 32'(am(0)), 450);
        fire[1] = 1'b0;
        err_clr[1] = 1'b1;
        tick();
        err_clr[1] = 1'b0;
        check("ch1_err_clr", 32'(error[1]), 0);

        // 4: wrong / multi-hot mode blocks firing and flags error; set beats clear
        mode_sel = 4'b0100;
        fire[0] = 1'b1;
        tick();
        check("mode_ammo", 32'(am(0)), 450);
        check("mode_shot", 32'(shot[0]), 0);
        check("mode_err", 32'(error[0]), 1);
        mode_sel = 4'b0110;
        err_clr[0] = 1'b1;
        tick();
        check("multihot_ammo", 32'(am(0)), 450);
        check("set_wins_clr", 32'(error[0]), 1);
        fire[0] = 1'b0;
        mode_sel = 4'b0010;
        tick();
        err_clr[0] = 1'b0;
        check("err_clr0", 32'(error[0]), 0);

        // 5: capacity clamp, over-capacity load (511 is the largest 9-bit value, above 500)
        max_val[0 +: W] = 200;
        set_max[0] = 1'b1;
        tick();
        set_max[0] = 1'b0;
        check("clamp200", 32'(am(0)), 200);
        fire[0] = 1'b1;
        tick();
        fire[0] = 1'b0;
        check("after_clamp_fire", 32'(am(0)), 195);
        max_val[0 +: W] = 500;
        set_max[0] = 1'b1;
        tick();
        set_max[0] = 1'b0;
        check("raise_cap_noclamp", 32'(am(0)), 195);
        load_val[0 +: W] = 511;
        load[0] = 1'b1;
        tick();
        load[0] = 1'b0;
        check("overcap_err", 32'(error[0]), 1);
        check("overcap_busy", 32'(busy[0]), 1);
        repeat (4) tick();
        check("overcap_ammo", 32'(am(0)), 500);
        err_clr[0] = 1'b1;
        tick();
        err_clr[0] = 1'b0;
        max_val[0 +: W] = 0;
        set_max[0] = 1'b1;
        tick();
        set_max[0] = 1'b0;
        check("clamp_zero", 32'(am(0)), 0);
        check("clamp_zero_err", 32'(error[0]), 0);
        fire[0] = 1'b1;
        tick();
        fire[0] = 1'b0;
        check("empty_fire_err", 32'(error[0]), 1);
        check("empty_fire_shot", 32'(shot[0]), 0);

        // load and fire together: reload wins, no shot
        load_val[W +: W] = 20;
        load[1] = 1'b1;
        fire[1] = 1'b1;
        tick();
        load[1] = 1'b0;
        fire[1] = 1'b0;
        check("ldfire_shot", 32'(shot[1]), 0);
        check("ldfire_busy", 32'(busy[1]), 1);
        check("ldfire_err", 32'(error[1]), 0);
        repeat (4) tick();
        check("ldfire_ammo", 32'(am(1)), 20);

        // rate 0 shoots without consuming; rate above ammo saturates at 0
        rate[W +: W] = 0;
        fire[1] = 1'b1;
        tick();
        check("rate0_shot", 32'(shot[1]), 1);
        check("rate0_ammo", 32'(am(1)), 20);
        rate[W +: W] = 25;
        tick();
        check("sat_shot", 32'(shot[1]), 1);
        check("sat_ammo", 32'(am(1)), 0);
        fire[1] = 1'b0;
        tick();

        // asynchronous reset mid-reload, then capacity back to default
        do_load(1, 30);
        check("pre_rst_ammo", 32'(am(1)), 30);
        load_val[W +: W] = 100;
        load[1] = 1'b1;
        tick();
        load[1] = 1'b0;
        tick();
        check("mid_busy", 32'(busy[1]), 1);
        check("mid_ammo_old", 32'(am(1)), 30);
        #1 rst = 1'b0;
        #1;
        check("async_ammo", 32'(ammo), 0);
        check("async_busy", 32'(busy), 0);
        check("async_err", 32'(error), 0);
        tick();
        rst = 1'b1;
        tick();
        do_load(1, 511);
        check("cap_restored", 32'(am(1)), 500);
        check("cap_restored_err", 32'(error[1]), 1);

`ifdef AUTO_RELOAD_EN
        // 6: auto reload with the last loaded value, then reset mid-reload
        do_load(0, 10);
        mode_sel = 4'b0010;
        rate[0 +: W] = 5;
        fire[0] = 1'b1;
        tick();
        check("ar_five", 32'(am(0)), 5);
        tick();
        check("ar_zero", 32'(am(0)), 0);
        check("ar_busy", 32'(busy[0]), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_hold_busy", 32'(busy[0]), 1);
            check("ar_hold_ammo", 32'(am(0)), 0);
        end
        tick();
        check("ar_refill", 32'(am(0)), 10);
        check("ar_refill_busy", 32'(busy[0]), 0);
        tick();
        check("ar_five_again", 32'(am(0)), 5);
        tick();
        check("ar_busy_again", 32'(busy[0]), 1);
        #1 rst = 1'b0;
        #1;
        check("ar_rst_ammo", 32'(am(0)), 0);
        check("ar_rst_busy", 32'(busy[0]), 0);
        fire[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
